detect_event_stretcher: RTL and testbench

//  Parametrised multi-channel successor to the per-signal whistle/beep LED stretchers in the microphone top level.

---
 rtl/mic_detect_pkg.sv | 12 +
 rtl/event_stretch_chan.sv | 145 ++++++++++++++
 rtl/detect_event_stretcher.sv | 83 ++++++++
 tb/tb_detect_event_stretcher.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mic_detect_pkg.sv
// Shared types and constants for the microphone detection event stretchers.
package mic_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_ACTIVE
    } det_state_t;

    localparam int STRETCH_CYCLES_50M = 12_500_000;

endpackage

// File: rtl/event_stretch_chan.sv
// One detection channel: edge detect, N-in-window qualification, hold stretch
// and a saturating qualified-event counter. Qualification is granted externally.
module event_stretch_chan
    import mic_detect_pkg::*;
#(
    parameter int HOLD_CYCLES = STRETCH_CYCLES_50M,
    parameter int QUAL_PULSES = 1,
    parameter int QUAL_WINDOW = 1,
    parameter int RETRIGGER   = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_counts,
    input  logic             pulse,
    input  logic             grant,
    output logic             qual_req,
    output logic             active_nxt,
    output logic             active,
    output logic             rise,
    output logic [CNT_W-1:0] count
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int WIN_W  = $clog2(QUAL_WINDOW + 1);
    localparam int QCNT_W = $clog2(QUAL_PULSES + 1);

    det_state_t        state;
    logic              prev;
    logic              edge_det;
    logic              idle_edge;
    logic              hold_last;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [QCNT_W-1:0] qual_cnt;

    assign edge_det  = pulse & ~prev;
    assign hold_last = (state == ST_ACTIVE) && !(RETRIGGER != 0 && edge_det)
                       && (hold_cnt == HOLD_W'(1));

    // An edge seen on window expiry or hold expiry behaves as if the channel were idle.
    always_comb begin
        idle_edge = 1'b0;
        qual_req  = 1'b0;
        case (state)
            ST_IDLE:    idle_edge = edge_det;
            ST_QUALIFY: begin
                if (win_cnt == WIN_W'(QUAL_WINDOW))
                    idle_edge = edge_det;
                else if (edge_det && (qual_cnt == QCNT_W'(QUAL_PULSES - 1)))
                    qual_req = 1'b1;
            end
            ST_ACTIVE:  if (hold_last) idle_edge = edge_det;
            default:    idle_edge = 1'b0;
        endcase
        if (idle_edge && (QUAL_PULSES == 1))
            qual_req = 1'b1;
        qual_req = qual_req & enable;
    end

    always_comb begin
        active_nxt = active;
        if (!enable)
            active_nxt = 1'b0;
        else if (qual_req)
            active_nxt = grant;
        else if (hold_last)
            active_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            prev     <= 1'b0;
            hold_cnt <= '0;
            win_cnt  <= '0;
            qual_cnt <= '0;
            active   <= 1'b0;
            rise     <= 1'b0;
            count    <= '0;
        end else begin
            prev   <= pulse;
            active <= active_nxt;
            rise   <= qual_req & grant & ~active;

            if (clear_counts)
                count <= '0;
            else if (qual_req && grant && (count != '1))
                count <= count + 1'b1;

            if (!enable) begin
                state <= ST_IDLE;
            end else if (qual_req) begin
                if (grant) begin
                    state    <= ST_ACTIVE;
                    hold_cnt <= HOLD_W'(HOLD_CYCLES);
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (edge_det) begin
                            state    <= ST_QUALIFY;
                            qual_cnt <= QCNT_W'(1);
                            win_cnt  <= WIN_W'(1);
                        end
                    end
                    ST_QUALIFY: begin
                        if (win_cnt == WIN_W'(QUAL_WINDOW)) begin
                            if (edge_det) begin
                                qual_cnt <= QCNT_W'(1);
                                win_cnt  <= WIN_W'(1);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            if (edge_det)
                                qual_cnt <= qual_cnt + 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (RETRIGGER != 0 && edge_det) begin
                            hold_cnt <= HOLD_W'(HOLD_CYCLES);
                        end else if (hold_cnt == HOLD_W'(1)) begin
                            if (edge_det) begin
                                state    <= ST_QUALIFY;
                                qual_cnt <= QCNT_W'(1);
                                win_cnt  <= WIN_W'(1);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/detect_event_stretcher.sv
// Multi-channel detection event stretcher: per-channel qualify/stretch/count,
// optional exclusive fixed-priority arbitration and a registered any-active flag.
module detect_event_stretcher
    import mic_detect_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int HOLD_CYCLES = STRETCH_CYCLES_50M,
    parameter int QUAL_PULSES = 1,
    parameter int QUAL_WINDOW = 1,
    parameter int RETRIGGER   = 1,
    parameter int EXCLUSIVE   = 0,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_counts,
    input  logic [NCH-1:0]       pulse_in,
    output logic [NCH-1:0]       active_out,
    output logic [NCH-1:0]       rise_out,
    output logic                 any_active,
    output logic [NCH*CNT_W-1:0] event_count
);

    if (NCH < 1)                   begin : g_bad_nch    $error("NCH must be >= 1");                   end
    if (HOLD_CYCLES < 1)           begin : g_bad_hold   $error("HOLD_CYCLES must be >= 1");           end
    if (QUAL_PULSES < 1)           begin : g_bad_qp     $error("QUAL_PULSES must be >= 1");           end
    if (QUAL_WINDOW < QUAL_PULSES) begin : g_bad_window $error("QUAL_WINDOW must be >= QUAL_PULSES"); end
    if (CNT_W < 1)                 begin : g_bad_cnt    $error("CNT_W must be >= 1");                 end

    logic [NCH-1:0] qual_req;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] active_nxt;
    logic [NCH-1:0] other_active;
    logic           taken;

    // Lowest requesting index claims the grant; nobody qualifies while another channel holds.
    always_comb begin
        grant        = '0;
        other_active = '0;
        taken        = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            other_active = active_out & ~(NCH'(1) << k);
            if (EXCLUSIVE == 0) begin
                grant[k] = 1'b1;
            end else begin
                grant[k] = ~taken & (other_active == '0);
                if (qual_req[k])
                    taken = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        event_stretch_chan #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .QUAL_PULSES(QUAL_PULSES),
            .QUAL_WINDOW(QUAL_WINDOW),
            .RETRIGGER  (RETRIGGER),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .enable      (enable),
            .clear_counts(clear_counts),
            .pulse       (pulse_in[k]),
            .grant       (grant[k]),
            .qual_req    (qual_req[k]),
            .active_nxt  (active_nxt[k]),
            .active      (active_out[k]),
            .rise        (rise_out[k]),
            .count       (event_count[k*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            any_active <= 1'b0;
        else
            any_active <= |active_nxt;
    end

endmodule

// File: tb/tb_detect_event_stretcher.sv
// Directed bench for detect_event_stretcher: table of per-cycle pulse masks with
// expected activity masks, plus hand sequences for reset, saturation, clear and enable.
module tb_detect_event_stretcher;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       enable       = 1'b0;
    logic       clear_counts = 1'b0;
    logic [1:0] pulse_in     = 2'b00;

    logic [1:0] act_o [3];
    logic [1:0] rise_o[3];
    logic       any_o [3];
    logic [7:0] cnt_o [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // dut 0: default test config, dut 1: no retrigger, dut 2: single-pulse exclusive
    detect_event_stretcher #(.NCH(2), .HOLD_CYCLES(10), .QUAL_PULSES(2), .QUAL_WINDOW(8),
                             .RETRIGGER(1), .EXCLUSIVE(0), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .clear_counts(clear_counts),
        .pulse_in(pulse_in), .active_out(act_o[0]), .rise_out(rise_o[0]),
        .any_active(any_o[0]), .event_count(cnt_o[0]));

    detect_event_stretcher #(.NCH(2), .HOLD_CYCLES(10), .QUAL_PULSES(2), .QUAL_WINDOW(8),
                             .RETRIGGER(0), .EXCLUSIVE(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .clear_counts(clear_counts),
        .pulse_in(pulse_in), .active_out(act_o[1]), .rise_out(rise_o[1]),
        .any_active(any_o[1]), .event_count(cnt_o[1]));

    detect_event_stretcher #(.NCH(2), .HOLD_CYCLES(10), .QUAL_PULSES(1), .QUAL_WINDOW(8),
                             .RETRIGGER(1), .EXCLUSIVE(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .clear_counts(clear_counts),
        .pulse_in(pulse_in), .active_out(act_o[2]), .rise_out(rise_o[2]),
        .any_active(any_o[2]), .event_count(cnt_o[2]));

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] act0;
        logic [31:0] rise0;
        logic [31:0] act1;
        logic [31:0] rise1;
        logic [31:0] cnt0;
        logic [31:0] cnt1;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] bit_at(input int n);
        return span(n, n);
    endfunction

    function automatic vec_t make_vec(input string name, input int dut,
                                      input logic [31:0] p0, input logic [31:0] p1,
                                      input logic [31:0] act0, input logic [31:0] rise0,
                                      input logic [31:0] act1, input logic [31:0] rise1,
                                      input int cnt0, input int cnt1);
        vec_t v;
        v.name = name; v.dut = dut; v.p0 = p0; v.p1 = p1;
        v.act0 = act0; v.rise0 = rise0; v.act1 = act1; v.rise1 = rise1;
        v.cnt0 = cnt0; v.cnt1 = cnt1;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0, the first cycle with reset low.
    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b1;
        clear_counts = 1'b0;
        pulse_in     = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, output logic [31:0] a0, output logic [31:0] r0,
                                  output logic [31:0] a1, output logic [31:0] r1,
                                  output logic [31:0] an);
        a0 = '0; r0 = '0; a1 = '0; r1 = '0; an = '0;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            pulse_in = {v.p1[c], v.p0[c]};
            @(negedge clk);
            a0[c] = act_o[v.dut][0];
            r0[c] = rise_o[v.dut][0];
            a1[c] = act_o[v.dut][1];
            r1[c] = rise_o[v.dut][1];
            an[c] = any_o[v.dut];
            step();
        end
        pulse_in = 2'b00;
    endtask

    initial begin
        logic [31:0] a0, r0, a1, r1, an;
        logic [31:0] acc;

        vecs[0] = make_vec("basic",       0, bit_at(5) | bit_at(9), '0,
                           span(10, 19), bit_at(10), '0, '0, 1, 0);
        vecs[1] = make_vec("win_expire",  0, bit_at(5) | bit_at(13), '0,
                           '0, '0, '0, '0, 0, 0);
        vecs[2] = make_vec("win_restart", 0, bit_at(5) | bit_at(13) | bit_at(15), '0,
                           span(16, 25), bit_at(16), '0, '0, 1, 0);
        vecs[3] = make_vec("retrig",      0, bit_at(5) | bit_at(9) | bit_at(15), '0,
                           span(10, 25), bit_at(10), '0, '0, 1, 0);
        vecs[4] = make_vec("no_retrig",   1, bit_at(5) | bit_at(9) | bit_at(15), '0,
                           span(10, 19), bit_at(10), '0, '0, 1, 0);
        vecs[5] = make_vec("level",       2, span(2, 31), '0,
                           span(3, 12), bit_at(3), '0, '0, 1, 0);
        vecs[6] = make_vec("exclusive",   2, bit_at(3), bit_at(3) | bit_at(8) | bit_at(20),
                           span(4, 13), bit_at(4), span(21, 30), bit_at(21), 1, 1);
        vecs[7] = make_vec("ch1_basic",   0, '0, bit_at(2) | bit_at(4),
                           '0, '0, span(5, 14), bit_at(5), 0, 1);

        // Reset state of every instance right after release
        do_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check_output($sformatf("reset_state_%0d", d),
                         {19'd0, act_o[d], rise_o[d], any_o[d], cnt_o[d]}, '0);
        step();

        // Reset held while edges arrive keeps everything quiet
        reset = 1'b1;
        acc   = '0;
        for (int c = 0; c < 20; c++) begin
            pulse_in = (c == 5 || c == 9) ? 2'b01 : 2'b00;
            @(negedge clk);
            acc = acc | {19'd0, act_o[0], rise_o[0], any_o[0], cnt_o[0]};
            step();
        end
        check_output("reset_held", acc, '0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], a0, r0, a1, r1, an);
            check_output({vecs[i].name, "_act0"},  a0, vecs[i].act0);
            check_output({vecs[i].name, "_rise0"}, r0, vecs[i].rise0);
            check_output({vecs[i].name, "_act1"},  a1, vecs[i].act1);
            check_output({vecs[i].name, "_rise1"}, r1, vecs[i].rise1);
            check_output({vecs[i].name, "_any"},   an, vecs[i].act0 | vecs[i].act1);
            check_output({vecs[i].name, "_cnt0"},  {28'd0, cnt_o[vecs[i].dut][3:0]}, vecs[i].cnt0);
            check_output({vecs[i].name, "_cnt1"},  {28'd0, cnt_o[vecs[i].dut][7:4]}, vecs[i].cnt1);
        end

        // Counter saturation on the single-pulse instance, then clear against an increment
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pulse_in = 2'b01;
            step();
            pulse_in = 2'b00;
            repeat (11) step();
            if (i == 14)
                check_output("sat_at_15", {28'd0, cnt_o[2][3:0]}, 32'd15);
        end
        check_output("sat_hold", {28'd0, cnt_o[2][3:0]}, 32'd15);
        check_output("sat_ch1_zero", {28'd0, cnt_o[2][7:4]}, 32'd0);
        pulse_in     = 2'b01;
        clear_counts = 1'b1;
        step();
        pulse_in     = 2'b00;
        clear_counts = 1'b0;
        check_output("clear_vs_inc", {28'd0, cnt_o[2][3:0]}, 32'd0);
        check_output("clear_still_active", {31'd0, act_o[2][0]}, 32'd1);

        // Enable dropped mid-hold; re-enable needs fresh edges
        do_reset();
        acc = '0;
        for (int c = 0; c < 40; c++) begin
            pulse_in = (c == 5 || c == 9 || c == 31 || c == 33) ? 2'b01 : 2'b00;
            enable   = !(c >= 13 && c < 16);
            @(negedge clk);
            if (c == 12)
                check_output("en_before", {31'd0, act_o[0][0]}, 32'd1);
            if (c == 14) begin
                check_output("en_drop", {31'd0, act_o[0][0]}, 32'd0);
                check_output("en_drop_any", {31'd0, any_o[0]}, 32'd0);
            end
            if (c >= 16 && c <= 30)
                acc = acc | {30'd0, act_o[0][0], rise_o[0][0]};
            if (c == 34)
                check_output("en_fresh_rise", {31'd0, rise_o[0][0]}, 32'd1);
            if (c == 35)
                check_output("en_count", {28'd0, cnt_o[0][3:0]}, 32'd2);
            step();
        end
        check_output("en_no_rearm", acc, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
